// File: rtl/johnson_counter_gen.sv
// Parametrised N-flop Johnson counter with enable, direction, clear/load, phase decode and tc strobe.
// Define JOHNSON_SELF_CORRECT_EN to enable illegal-state self-correction and the sticky err flag.
module johnson_counter_gen #(
  parameter int NUM_FLOPS = 5,
  localparam int PW = $clog2(2 * NUM_FLOPS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 dir,
  input  logic                 clr,
  input  logic                 ld,
  input  logic [NUM_FLOPS-1:0] ld_val,
  output logic [NUM_FLOPS-1:0] q,
  output logic                 q_out,
  output logic [PW-1:0]        phase,
  output logic                 tc,
  output logic                 err
);

  logic [NUM_FLOPS-1:0] q_next;
  logic [NUM_FLOPS-1:0] shift_val;
  int                   ones;

  always_comb begin
    if (dir) shift_val = {~q[0], q[NUM_FLOPS-1:1]};
    else     shift_val = {q[NUM_FLOPS-2:0], ~q[NUM_FLOPS-1]};
  end

  // Phase is a pure function of q; illegal codes still decode to a defined value.
  always_comb begin
    ones = 0;
    for (int i = 0; i < NUM_FLOPS; i++) ones = ones + int'(q[i]);
    if (q == '0)    phase = '0;
    else if (q[0])  phase = PW'(ones);
    else            phase = PW'(2 * NUM_FLOPS - ones);
  end

  assign q_out = q[NUM_FLOPS-1];
  assign tc = en & ~clr & ~ld &
              (dir ? (phase == '0) : (phase == PW'(2 * NUM_FLOPS - 1)));

`ifdef JOHNSON_SELF_CORRECT_EN
  logic legal;
  logic err_next;
  int   edges;

  // Legal codes have at most one 0/1 boundary inside q, ignoring the wrap.
  always_comb begin
    edges = 0;
    for (int i = 0; i < NUM_FLOPS - 1; i++) edges = edges + int'(q[i] ^ q[i+1]);
    legal = (edges <= 1);
  end

  always_comb begin
    q_next   = q;
    err_next = err;
    if (clr) begin
      q_next   = '0;
      err_next = 1'b0;
    end else if (ld) begin
      q_next = ld_val;
    end else if (en) begin
      if (!legal) begin
        q_next   = '0;
        err_next = 1'b1;
      end else begin
        q_next = shift_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q   <= '0;
      err <= 1'b0;
    end else begin
      q   <= q_next;
      err <= err_next;
    end
  end
`else
  always_comb begin
    q_next = q;
    if (clr)     q_next = '0;
    else if (ld) q_next = ld_val;
    else if (en) q_next = shift_val;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= '0;
    else      q <= q_next;
  end

  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_johnson_counter_gen.sv
// Randomized and directed bench for johnson_counter_gen against a phase-index reference model.
module tb_johnson_counter_gen;
  localparam int N  = 5;
  localparam int PW = $clog2(2 * N);

  logic          clk;
  logic          rst;
  logic          en;
  logic          dir;
  logic          clr;
  logic          ld;
  logic [N-1:0]  ld_val;
  logic [N-1:0]  q;
  logic          q_out;
  logic [PW-1:0] phase;
  logic          tc;
  logic          err;

  int tests_run;
  int tests_failed;
  int p;        // model: current phase index 0..2N-1
  int tc_seen;

  johnson_counter_gen #(.NUM_FLOPS(N)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .ld(ld),
    .ld_val(ld_val), .q(q), .q_out(q_out), .phase(phase), .tc(tc), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Phase p is p ones filling from bit 0, then ones draining out of bit 0.
  function automatic logic [N-1:0] q_of(input int ph);
    logic [63:0] mask;
    if (ph <= N) mask = (64'd1 << ph) - 64'd1;
    else         mask = ((64'd1 << (2 * N - ph)) - 64'd1) << (ph - N);
    return mask[N-1:0];
  endfunction

  function automatic int phase_of(input logic [N-1:0] v);
    for (int i = 0; i < 2 * N; i++) if (q_of(i) == v) return i;
    return -1;
  endfunction

  task automatic drive(input logic e, input logic d, input logic c, input logic l,
                       input logic [N-1:0] lv);
    en = e; dir = d; clr = c; ld = l; ld_val = lv;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One cycle with legal-only stimulus: check outputs against the model, clock, advance model.
  task automatic step(input logic e, input logic d, input logic c, input logic l,
                      input logic [N-1:0] lv);
    logic          exp_tc;
    logic [N-1:0]  exp_q;
    drive(e, d, c, l, lv);
    #1;
    exp_q  = q_of(p);
    exp_tc = e && !c && !l && (d ? (p == 0) : (p == 2 * N - 1));
    tests_run++;
    if (q !== exp_q) begin
      tests_failed++;
      $display("FAIL step_q: got %b expected %b", q, exp_q);
    end
    tests_run++;
    if (phase !== PW'(p)) begin
      tests_failed++;
      $display("FAIL step_phase: got %0d expected %0d", phase, p);
    end
    tests_run++;
    if (q_out !== exp_q[N-1]) begin
      tests_failed++;
      $display("FAIL step_q_out: got %b expected %b", q_out, exp_q[N-1]);
    end
    tests_run++;
    if (tc !== exp_tc) begin
      tests_failed++;
      $display("FAIL step_tc: got %b expected %b (phase %0d en %b dir %b)", tc, exp_tc, p, e, d);
    end
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("FAIL step_err: got %b expected 0", err);
    end
    if (tc === 1'b1) tc_seen++;
    @(posedge clk);
    if (c)      p = 0;
    else if (l) p = phase_of(lv);
    else if (e) p = d ? (p + 2 * N - 1) % (2 * N) : (p + 1) % (2 * N);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, '0);
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    tests_run++;
    if (q !== '0 || phase !== '0 || q_out !== 1'b0 || tc !== 1'b0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: got q=%b phase=%0d q_out=%b tc=%b err=%b expected all zero",
               q, phase, q_out, tc, err);
    end
    @(negedge clk);
    rst = 1'b1;
    p = 0;
  endtask

  task automatic test_forward();
    int   toggles;
    logic prev;
    toggles = 0;
    tc_seen = 0;
    for (int i = 0; i < 20; i++) begin
      prev = q_out;
      step(1, 0, 0, 0, '0);
      if (q_out !== prev) toggles++;
    end
    tests_run++;
    if (toggles != 4) begin
      tests_failed++;
      $display("FAIL fwd_toggles: got %0d expected 4", toggles);
    end
    tests_run++;
    if (tc_seen != 2) begin
      tests_failed++;
      $display("FAIL fwd_tc_pulses: got %0d expected 2", tc_seen);
    end
  endtask

  task automatic test_reverse();
    step(0, 0, 1, 0, '0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, '0);
    tc_seen = 0;
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, '0);
    tests_run++;
    if (q !== 5'b00001 || phase !== PW'(1) || tc_seen != 0) begin
      tests_failed++;
      $display("FAIL rev_steps: got q=%b phase=%0d tc_pulses=%0d expected 00001 1 0",
               q, phase, tc_seen);
    end
    step(0, 0, 1, 0, '0);
    step(1, 1, 0, 0, '0);
    tests_run++;
    if (q !== 5'b10000 || phase !== PW'(9)) begin
      tests_failed++;
      $display("FAIL rev_wrap: got q=%b phase=%0d expected 10000 9", q, phase);
    end
  endtask

  task automatic test_priority();
    step(1, 0, 0, 0, '0);
    step(1, 0, 1, 1, 5'b00111);
    tests_run++;
    if (q !== '0) begin
      tests_failed++;
      $display("FAIL prio_clr: got %b expected 00000", q);
    end
    step(1, 0, 0, 1, 5'b00111);
    tests_run++;
    if (q !== 5'b00111 || phase !== PW'(3)) begin
      tests_failed++;
      $display("FAIL prio_ld: got q=%b phase=%0d expected 00111 3", q, phase);
    end
    step(0, 1, 0, 0, '0);
  endtask

  task automatic test_illegal();
    drive(0, 0, 0, 1, 5'b01010);
    tick();
    tests_run++;
    if (q !== 5'b01010 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL ill_load: got q=%b err=%b expected 01010 0", q, err);
    end
`ifdef JOHNSON_SELF_CORRECT_EN
    drive(0, 0, 0, 0, '0);
    tick();
    tests_run++;
    if (q !== 5'b01010 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL ill_hold: got q=%b err=%b expected 01010 0", q, err);
    end
    drive(1, 0, 0, 0, '0);
    tick();
    tests_run++;
    if (q !== '0 || err !== 1'b1) begin
      tests_failed++;
      $display("FAIL ill_correct: got q=%b err=%b expected 00000 1", q, err);
    end
    for (int i = 0; i < 10; i++) tick();
    tests_run++;
    if (q !== '0 || err !== 1'b1) begin
      tests_failed++;
      $display("FAIL ill_sticky: got q=%b err=%b expected 00000 1", q, err);
    end
    drive(0, 0, 1, 0, '0);
    tick();
    tests_run++;
    if (q !== '0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL ill_clr: got q=%b err=%b expected 00000 0", q, err);
    end
`else
    drive(1, 0, 0, 0, '0);
    tick();
    tests_run++;
    if (q !== 5'b10101 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL ill_shift: got q=%b err=%b expected 10101 0", q, err);
    end
    drive(0, 0, 1, 0, '0);
    tick();
`endif
    p = 0;
  endtask

  task automatic test_async_reset();
    step(0, 0, 1, 0, '0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, '0);
    tests_run++;
    if (phase !== PW'(6)) begin
      tests_failed++;
      $display("FAIL arst_pre: got phase=%0d expected 6", phase);
    end
    drive(1, 0, 0, 0, '0);
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if (q !== '0 || phase !== '0 || tc !== 1'b0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL arst_mid: got q=%b phase=%0d tc=%b err=%b expected 0 0 0 0", q, phase, tc, err);
    end
    @(negedge clk);
    rst = 1'b1;
    p = 0;
    step(1, 0, 0, 0, '0);
    tests_run++;
    if (phase !== PW'(1)) begin
      tests_failed++;
      $display("FAIL arst_resume: got phase=%0d expected 1", phase);
    end
  endtask

  task automatic test_random();
    logic e, d, c, l;
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(0, 3) != 0);
      d = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 24) == 0);
      l = ($urandom_range(0, 14) == 0);
      step(e, d, c, l, q_of(int'($urandom_range(0, 2 * N - 1))));
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    tc_seen = 0;
    p = 0;
    test_reset();
    test_forward();
    test_reverse();
    test_priority();
    test_illegal();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
